// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor: computes a - b one nibble per clock, LSB first.
// Optional signed-overflow flag output enabled by defining NIBBLE_SUB_SIGNED_OVF_EN.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic            bin_q, bin_d;
  logic            borrow_q, borrow_d;
  logic            ovf_q, ovf_d;

  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];
  logic [3:0] a_sel, b_sel;
  logic [4:0] sub_nib;
  logic       last_nib;

  // Slice the latched operands into nibbles once so the datapath is a simple mux.
  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sel = a_nib[i];
        b_sel = b_nib[i];
      end
    end
  end

  assign sub_nib  = {1'b0, a_sel} - {1'b0, b_sel} - {4'b0, bin_q};
  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          bin_d    = 1'b0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) diff_d[4*i +: 4] = sub_nib[3:0];
        end
        bin_d = sub_nib[4];
        cnt_d = cnt_q + 1'b1;
        if (last_nib) begin
          borrow_d = sub_nib[4];
          // Signed overflow: operand signs differ and result sign differs from a.
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_nib[3] != a_q[WIDTH-1]);
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  logic        ovf;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
    else pass_cnt++;
  endtask

  // Wait after the start edge until done, returning edge count and busy-cycle count.
  task automatic wait_done(output int lat, output int busy_cycles, output bit timed_out);
    lat = 0;
    busy_cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_d, input logic exp_b, input logic exp_ovf);
    int lat;
    int bc;
    bit to;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_rise: got %b expected 1", name, busy);
    else pass_cnt++;
    wait_done(lat, bc, to);
    total_cnt++;
    if (to) $display("FAIL %s done_timeout: got no done expected done within 20 cycles", name);
    else pass_cnt++;
    total_cnt++;
    if (lat != 4) $display("FAIL %s latency: got %0d expected 4 (done after start edge + 4 edges)", name, lat);
    else pass_cnt++;
    total_cnt++;
    if (bc != 4) $display("FAIL %s busy_cycles: got %0d expected 4", name, bc);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
    else pass_cnt++;
    check_val({name, " diff"}, diff, exp_d);
    check_val({name, " borrow"}, {15'b0, borrow}, {15'b0, exp_b});
`ifdef NIBBLE_SUB_SIGNED_OVF_EN
    check_val({name, " ovf"}, {15'b0, ovf}, {15'b0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("note: unexpected x");
`endif
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL %s done_width: got %b expected 0 one cycle later", name, done);
    else pass_cnt++;
    check_val({name, " diff_hold"}, diff, exp_d);
    $display("op %s: a=0x%04h b=0x%04h diff=0x%04h borrow=%b latency=%0d", name, av, bv, diff, borrow, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    #12;
    check_val("reset busy", {15'b0, busy}, 16'h0);
    check_val("reset done", {15'b0, done}, 16'h0);
    check_val("reset diff", diff, 16'h0);
    check_val("reset borrow", {15'b0, borrow}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: busy=%b done=%b diff=0x%04h borrow=%b", busy, done, diff, borrow);
  endtask

  task automatic test_basic();
    run_op("2-1", 16'h0002, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op("ripple", 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_op("wrap", 16'h0000, 16'h0008, 16'hFFF8, 1'b1, 1'b0);
    run_op("equal", 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int lat;
    int bc;
    bit to;
    @(negedge clk);
    a = 16'h0006;
    b = 16'h0004;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'hFFFF;
    b = 16'h0000;
    wait_done(lat, bc, to);
    total_cnt++;
    if (to || lat != 4) $display("FAIL b2b first_latency: got %0d (timeout=%0d) expected 4", lat, to);
    else pass_cnt++;
    check_val("b2b first diff", diff, 16'h0002);
    check_val("b2b first borrow", {15'b0, borrow}, 16'h0);
    @(negedge clk);
    check_val("b2b idle busy", {15'b0, busy}, 16'h0);
    check_val("b2b idle done", {15'b0, done}, 16'h0);
    @(negedge clk);
    check_val("b2b restart busy", {15'b0, busy}, 16'h1);
    start = 1'b0;
    wait_done(lat, bc, to);
    total_cnt++;
    if (to || lat != 3) $display("FAIL b2b second_latency: got %0d (timeout=%0d) expected 3", lat, to);
    else pass_cnt++;
    check_val("b2b second diff", diff, 16'hFFFF);
    check_val("b2b second borrow", {15'b0, borrow}, 16'h0);
    $display("b2b: second diff=0x%04h borrow=%b", diff, borrow);
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    @(negedge clk);
    a = 16'h00F0;
    b = 16'h000F;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("midrun partial diff", diff, 16'h00E1);
    rst_n = 1'b0;
    #1;
    check_val("midrun rst busy", {15'b0, busy}, 16'h0);
    check_val("midrun rst done", {15'b0, done}, 16'h0);
    check_val("midrun rst diff", diff, 16'h0);
    check_val("midrun rst borrow", {15'b0, borrow}, 16'h0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check_val("midrun no done", seen_done[15:0], 16'h0);
    $display("reset mid-run: done pulses seen=%0d", seen_done);
    run_op("post-rst", 16'h0005, 16'h000A, 16'hFFFB, 1'b1, 1'b0);
  endtask

  task automatic test_ovf();
    run_op("ovf neg-pos", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op("ovf pos-neg", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
    run_op("ovf none", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
    test_ovf();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
